rr_onehot_arbiter: RTL and testbench
====================================

Name: rr_onehot_arbiter

Overview:
- Round-robin arbiter that shares one resource among NUM_REQ requesters.
- Picks a winner index, then drives a registered one-hot grant through a binary-to-one-hot decoder.
- Holds the grant until the owner releases it or a hold timeout expires.
- Sits in front of any shared datapath whose select is a one-hot vector.

Parameters:
- NUM_REQ, 16, number of requesters; power of two, 2..16.
- IDX_W, $clog2(NUM_REQ) (4 at default), width of the grant index.
- MAX_HOLD, 8, maximum consecutive cycles a grant may be held; 1..255.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset (asserted when 0).
- req_i  input  NUM_REQ  request vector; bit k = requester k wants the resource.
- done_i  input  1  current owner releases the resource this cycle.
- gnt_o  output  NUM_REQ  registered one-hot grant; all-zero when no owner.
- gnt_idx_o  output  IDX_W  binary index of current owner; 0 when no owner.
- gnt_valid_o  output  1  high while a grant is active.
- timeout_o  output  1  one-cycle pulse when a grant is revoked by the hold limit.

Behaviour:
- Reset (reset==0 at a clk edge):
  - gnt_o=0, gnt_idx_o=0, gnt_valid_o=0, timeout_o=0.
  - State=IDLE, priority pointer ptr=0, hold counter=0.
  - Reset mid-grant drops the grant on that same edge.
- FSM states are IDLE and GRANT.
- IDLE:
  - If req_i==0, stay in IDLE; outputs stay zero.
  - Otherwise the winner is the first set bit of req_i scanning upward from ptr, wrapping from NUM_REQ-1 to 0.
  - Next edge: gnt_idx_o=winner, gnt_o=one-hot(winner), gnt_valid_o=1, hold counter=1, go to GRANT.
  - Latency: request seen in cycle N gives grant visible in cycle N+1.
- GRANT, release: release when done_i==1 OR req_i[gnt_idx_o]==0.
  - Next edge: go to IDLE, clear outputs, ptr=(gnt_idx_o+1) mod NUM_REQ.
- GRANT, timeout: if not released and hold counter==MAX_HOLD, revoke.
  - Same actions as release, plus timeout_o=1 for exactly that one cycle.
- GRANT, otherwise: hold counter increments; grant is unchanged.
  - Requests from other requesters never preempt the owner.
- A release and the timeout in the same cycle count as a release; timeout_o stays 0.
- After every release or timeout there is exactly one IDLE cycle before the next grant.
  - Peak grant rate is therefore one grant per 2 cycles.
- ptr changes only on release or timeout; fairness comes from rotating ptr past the last owner.
- Invariant: gnt_o is zero or one-hot, and gnt_o==(1<<gnt_idx_o) whenever gnt_valid_o==1.
- done_i is ignored in IDLE.
- Hold counter is 8 bits and never wraps, because MAX_HOLD<=255 forces exit first.

Decomposition:
- Package arb_pkg holds:
  - typedef enum logic {IDLE, GRANT} arb_state_t;
  - localparam DEF_NUM_REQ=16;
  - localparam DEF_MAX_HOLD=8.
- One sub-module, bin_to_onehot (parameters IDX_W and NUM_REQ).
  - Purely combinational: maps the winner index to a NUM_REQ-bit one-hot vector.
  - Its output feeds the gnt_o register.
- The rotating priority search stays in the top module as a combinational function.

Test Plan:
- Reset: hold reset=0 for 2 cycles with req_i=16'hFFFF -> gnt_o=0, gnt_valid_o=0, timeout_o=0.
  - Release reset -> next cycle gnt_o=16'h0001, gnt_idx_o=0.
- Rotation: req_i=16'h0011 held, pulse done_i each grant.
  - Grants go idx 4, 0, 4, 0 in that order, each separated by one IDLE cycle.
  - (ptr starts at 0 and only reaches 4 once 0 has been served; first grant from reset is idx 0, then 4, 0, 4.)
- Wrap: with ptr at 15 after serving idx 14, req_i=16'h8002.
  - Grant idx 15 (gnt_o=16'h8000); after done_i, grant idx 1 (16'h0002).
- Timeout: req_i=16'h0100 held, done_i=0, MAX_HOLD=8.
  - gnt_o=16'h0100 for exactly 8 cycles, then timeout_o pulses for 1 cycle.
  - One IDLE cycle follows, then idx 8 is regranted.
- Owner drop: grant idx 3 active, req_i goes 16'h0008 -> 16'h0000.
  - gnt_valid_o falls on the next edge; timeout_o stays 0.
- Simultaneous: done_i=1 in the same cycle the counter hits MAX_HOLD.
  - Treated as a release: timeout_o=0, ptr advances normally.
- Reset mid-grant: reset=0 while gnt_o=16'h0020 -> all outputs 0 on the next edge.
  - After reset release, ptr=0 again.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and defaults for the round-robin one-hot arbiter.
// Imported by the arbiter top and its index decoder.
package arb_pkg;

  typedef enum logic {
    IDLE,
    GRANT
  } arb_state_t;

  localparam int DEF_NUM_REQ  = 16;
  localparam int DEF_MAX_HOLD = 8;

endpackage

// File: rtl/rr_onehot_arbiter_bin_to_onehot.sv
// Binary index to one-hot decoder feeding the grant register.
// Purely combinational.
module bin_to_onehot
  import arb_pkg::*;
#(
  parameter int IDX_W   = $clog2(DEF_NUM_REQ),
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic [IDX_W-1:0]   idx,
  output logic [NUM_REQ-1:0] onehot
);

  always_comb begin
    onehot      = '0;
    onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter with registered one-hot grant,
// owner release and a hold-time limit.
module rr_onehot_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int IDX_W    = $clog2(NUM_REQ),
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               done_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   gnt_idx_o,
  output logic               gnt_valid_o,
  output logic               timeout_o
);

  arb_state_t         state;
  logic [IDX_W-1:0]   ptr;
  logic [7:0]         hold_cnt;
  logic [IDX_W-1:0]   win_idx;
  logic [NUM_REQ-1:0] win_oh;
  logic               rel;
  logic               expire;

  // Rotate the request vector so ptr lands at bit 0,
  // take the lowest set bit, then undo the rotation.
  function automatic logic [IDX_W-1:0] rr_pick(
    input logic [NUM_REQ-1:0] req,
    input logic [IDX_W-1:0]   base
  );
    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [IDX_W-1:0]     off;
    dbl = {req, req} >> base;
    rot = dbl[NUM_REQ-1:0];
    off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = IDX_W'(i);
    end
    return base + off;
  endfunction

  always_comb win_idx = rr_pick(req_i, ptr);

  bin_to_onehot #(
    .IDX_W   (IDX_W),
    .NUM_REQ (NUM_REQ)
  ) u_dec (
    .idx    (win_idx),
    .onehot (win_oh)
  );

  assign rel    = done_i | ~req_i[gnt_idx_o];
  assign expire = (hold_cnt == 8'(MAX_HOLD));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      ptr         <= '0;
      hold_cnt    <= '0;
      gnt_o       <= '0;
      gnt_idx_o   <= '0;
      gnt_valid_o <= 1'b0;
      timeout_o   <= 1'b0;
    end else begin
      timeout_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (|req_i) begin
            state       <= GRANT;
            gnt_idx_o   <= win_idx;
            gnt_o       <= win_oh;
            gnt_valid_o <= 1'b1;
            hold_cnt    <= 8'd1;
          end
        end
        GRANT: begin
          if (rel || expire) begin
            state       <= IDLE;
            ptr         <= gnt_idx_o + 1'b1;
            gnt_o       <= '0;
            gnt_idx_o   <= '0;
            gnt_valid_o <= 1'b0;
            hold_cnt    <= '0;
            // a release wins over a coincident expiry
            timeout_o   <= ~rel;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Directed plus random bench for rr_onehot_arbiter
// against a behavioural owner/pointer model.
module tb_rr_onehot_arbiter;

  localparam int N  = 16;
  localparam int IW = 4;
  localparam int MH = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req_i;
  logic          done_i;
  logic [N-1:0]  gnt_o;
  logic [IW-1:0] gnt_idx_o;
  logic          gnt_valid_o;
  logic          timeout_o;

  int passed = 0;
  int total  = 0;

  int m_owner = -1;
  int m_ptr   = 0;
  int m_hold  = 0;
  bit m_to    = 1'b0;

  always #5 clk = ~clk;

  rr_onehot_arbiter #(
    .NUM_REQ  (N),
    .IDX_W    (IW),
    .MAX_HOLD (MH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_i       (req_i),
    .done_i      (done_i),
    .gnt_o       (gnt_o),
    .gnt_idx_o   (gnt_idx_o),
    .gnt_valid_o (gnt_valid_o),
    .timeout_o   (timeout_o)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance the model by one clock edge from the current inputs.
  task automatic model_step();
    bit let_go;
    if (!reset) begin
      m_owner = -1;
      m_ptr   = 0;
      m_hold  = 0;
      m_to    = 1'b0;
    end else if (m_owner < 0) begin
      m_to = 1'b0;
      if (req_i != '0) begin
        for (int k = 0; k < N; k++) begin
          if (m_owner < 0 && req_i[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
        end
        m_hold = 1;
      end
    end else begin
      let_go = done_i || !req_i[m_owner];
      if (let_go || m_hold == MH) begin
        m_ptr   = (m_owner + 1) % N;
        m_to    = !let_go;
        m_owner = -1;
        m_hold  = 0;
      end else begin
        m_to   = 1'b0;
        m_hold = m_hold + 1;
      end
    end
  endtask

  task automatic tick();
    logic [31:0] eg;
    model_step();
    @(posedge clk);
    #1;
    eg = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
    check("gnt", 32'(gnt_o), eg);
    check("idx", 32'(gnt_idx_o), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
    check("valid", 32'(gnt_valid_o), 32'(m_owner >= 0));
    check("timeout", 32'(timeout_o), 32'(m_to));
  endtask

  task automatic drive(
    input logic         r,
    input logic [N-1:0] q,
    input logic         d
  );
    reset  = r;
    req_i  = q;
    done_i = d;
    tick();
  endtask

  initial begin
    reset  = 1'b0;
    req_i  = '0;
    done_i = 1'b0;
    #2;

    drive(1'b0, 16'hFFFF, 1'b0);
    drive(1'b0, 16'hFFFF, 1'b0);
    check("rst_gnt", 32'(gnt_o), 32'h0);
    check("rst_valid", 32'(gnt_valid_o), 32'h0);
    check("rst_to", 32'(timeout_o), 32'h0);
    drive(1'b1, 16'hFFFF, 1'b0);
    check("first_gnt", 32'(gnt_o), 32'h0001);

    drive(1'b1, 16'h0011, 1'b1);
    check("rot_idle", 32'(gnt_valid_o), 32'h0);
    drive(1'b1, 16'h0011, 1'b0);
    check("rot_4a", 32'(gnt_idx_o), 32'd4);
    drive(1'b1, 16'h0011, 1'b1);
    drive(1'b1, 16'h0011, 1'b0);
    check("rot_0", 32'(gnt_idx_o), 32'd0);
    check("rot_0v", 32'(gnt_valid_o), 32'd1);
    drive(1'b1, 16'h0011, 1'b1);
    drive(1'b1, 16'h0011, 1'b0);
    check("rot_4b", 32'(gnt_idx_o), 32'd4);
    drive(1'b1, 16'h0011, 1'b1);

    drive(1'b1, 16'h4000, 1'b0);
    check("wrap_14", 32'(gnt_idx_o), 32'd14);
    drive(1'b1, 16'h4000, 1'b1);
    drive(1'b1, 16'h8002, 1'b0);
    check("wrap_15", 32'(gnt_o), 32'h8000);
    drive(1'b1, 16'h8002, 1'b1);
    drive(1'b1, 16'h8002, 1'b0);
    check("wrap_1", 32'(gnt_o), 32'h0002);
    drive(1'b1, 16'h8002, 1'b1);

    for (int i = 0; i < MH; i++) begin
      drive(1'b1, 16'h0100, 1'b0);
      check("hold", 32'(gnt_o), 32'h0100);
    end
    drive(1'b1, 16'h0100, 1'b0);
    check("to_pulse", 32'(timeout_o), 32'h1);
    check("to_gnt", 32'(gnt_o), 32'h0);
    drive(1'b1, 16'h0100, 1'b0);
    check("to_regnt", 32'(gnt_o), 32'h0100);
    check("to_clr", 32'(timeout_o), 32'h0);
    drive(1'b1, 16'h0000, 1'b0);

    drive(1'b1, 16'h0008, 1'b0);
    check("drop_own", 32'(gnt_idx_o), 32'd3);
    drive(1'b1, 16'h0000, 1'b0);
    check("drop_v", 32'(gnt_valid_o), 32'h0);
    check("drop_to", 32'(timeout_o), 32'h0);

    drive(1'b1, 16'h0010, 1'b0);
    for (int i = 1; i < MH; i++) drive(1'b1, 16'h0010, 1'b0);
    drive(1'b1, 16'h0010, 1'b1);
    check("sim_to", 32'(timeout_o), 32'h0);
    drive(1'b1, 16'h0031, 1'b0);
    check("sim_ptr", 32'(gnt_o), 32'h0020);

    drive(1'b0, 16'h0031, 1'b0);
    check("mid_rst", 32'(gnt_o), 32'h0);
    check("mid_rst_v", 32'(gnt_valid_o), 32'h0);
    drive(1'b1, 16'h0030, 1'b0);
    check("rst_ptr", 32'(gnt_o), 32'h0010);

    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 59) != 0);
      if ($urandom_range(0, 3) == 0)
        req_i = 16'($urandom) & 16'($urandom);
      done_i = ($urandom_range(0, 4) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
